return_stack: RTL and testbench
===============================

# return_stack

Hardware return-address stack (LIFO) for subroutine call/return in the single-cycle processor. It sits directly upstream of the program-counter register, beside the PC incrementer.
- On a call, it captures the 10-bit return address (PC+1) produced by the incrementer.
- On a return, it presents the saved address combinationally to the PC input multiplexer, so the PC loads it on the same clock edge that pops the entry.
- Full/empty status and sticky error flags go to the control unit.

## Interface
Parameters:
- WIDTH, 10, address width; matches the PC/incrementer width.
- DEPTH, 8, number of entries; any value from 2 to 16.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  store `d` as the new top entry (call).
- pop  in  1  remove the top entry (return).
- clr  in  1  synchronous clear of the stack pointer and the error flags.
- d  in  WIDTH  return address to push (PC+1).
- q  out  WIDTH  current top entry; combinational.
- empty  out  1  high when the stack holds 0 entries.
- full  out  1  high when the stack holds DEPTH entries.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- overflow  out  1  sticky; a push was attempted while full.
- underflow  out  1  sticky; a pop was attempted while empty.

## Operation
- **State:**
  - Entry array mem[0..DEPTH-1] of WIDTH bits.
  - Stack pointer sp in the range 0..DEPTH; sp is the entry count.
  - Two sticky flag flip-flops.
- **Reset (asynchronous):** sp=0, overflow=0, underflow=0. The array contents are not reset.
- **Outputs after reset:** q=0, empty=1, full=0, count=0, overflow=0, underflow=0.
- **Combinational outputs:**
  - q = mem[sp-1] when sp>0; q = 0 when sp=0.
  - empty = (sp==0); full = (sp==DEPTH); count = sp.
- **Per-edge actions, evaluated in priority order:**
  1. **clr:** sp←0, overflow←0, underflow←0. push and pop are ignored in that cycle.
  2. **push only, not full:** mem[sp]←d, sp←sp+1.
  3. **push only, full:** no write, sp unchanged, overflow←1.
  4. **pop only, not empty:** sp←sp-1. The entry is not erased.
  5. **pop only, empty:** sp unchanged, underflow←1.
  6. **push and pop together, not empty:** mem[sp-1]←d, sp unchanged (top replaced; tail call). This also applies when full; overflow is not set.
  7. **push and pop together, empty:** pop is illegal, so underflow←1; the push is performed (mem[0]←d, sp←1).
  8. **Neither push nor pop:** no change.
- **Sticky flags:** once set, remain set until reset or clr.
- **Width arithmetic:**
  - sp is exactly $clog2(DEPTH+1) bits.
  - sp never wraps: it saturates by rule at 0 and at DEPTH.
  - No arithmetic is performed on the data; d is stored verbatim.

## Timing
- **Pop/return path:** zero latency. q is valid combinationally during the return cycle, so the PC mux selects it and the PC loads it at the same rising edge that decrements sp.
- **Push:** written at the rising edge. The new top appears on q immediately after that edge, within the same clock period.
- **Same-cycle push+pop:** during the cycle, q shows the old top; after the edge, q shows d.
- **Reset mid-operation:** asserting reset at any time forces the reset values immediately, independent of clk. After reset deasserts, the first rising edge processes push/pop normally.
- **Input setup:** push, pop, clr and d must be stable before the rising edge (single-cycle control decode path). There is no internal input registering.

## Test plan
- **Reset and idle:**
  - Stimulus: assert reset mid-sequence, with sp=3.
  - Required: immediately empty=1, count=0, q=0, overflow=0, underflow=0, without waiting for a clock edge.
- **LIFO order:**
  - Stimulus: push 0x005, then 0x0A1, then 0x3FF.
  - Required: count=3 and q=0x3FF.
  - Then pop three times. Required: q reads 0x3FF, 0x0A1, 0x005 in the cycles before each pop edge. After the final pop: empty=1, q=0.
- **Overflow:**
  - Stimulus: push DEPTH=8 values 0x010..0x017, then push 0x2AA.
  - Required: full=1, count=8, q=0x017, overflow=1.
  - Then pop once. Required: q=0x016, overflow still 1.
- **Underflow and simultaneous-on-empty:**
  - Stimulus: from empty, pop.
  - Required: count=0, underflow=1.
  - Then clr. Required: underflow=0.
  - Then push+pop with d=0x123. Required: count=1, q=0x123, underflow=1.
- **Replace-top:**
  - Stimulus: with 0x001 and 0x002 stacked, push+pop with d=0x0FE.
  - Required: count=2, q=0x0FE.
  - Then pop. Required: q=0x001.
  - With the stack full, push+pop. Required: count stays 8, overflow stays 0.
- **clr priority:**
  - Stimulus: with 4 entries, assert clr with push=1 and pop=1.
  - Required: after the edge, count=0, empty=1, no write performed, both flags 0.

Source files
------------

// File: rtl/return_stack.sv
// Return-address LIFO for subroutine call/return.
// The top entry is presented combinationally so the PC can load it on the popping edge.
module return_stack #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           q,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned SpW   = $clog2(DEPTH + 1);
  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SpW-1:0]   sp_q, sp_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [SpW-1:0]   sp_m1;
  logic [AddrW-1:0] top_addr;
  logic [AddrW-1:0] waddr;
  logic             we;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == SpW'(DEPTH));
  assign sp_m1    = sp_q - SpW'(1);
  assign top_addr = sp_m1[AddrW-1:0];

  always_comb begin
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = '0;
    if (clr) begin
      sp_d        = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (push && pop) begin
      // Tail call replaces the top; on empty the pop is illegal but the push still lands.
      we = 1'b1;
      if (is_empty) begin
        underflow_d = 1'b1;
        waddr       = '0;
        sp_d        = SpW'(1);
      end else begin
        waddr = top_addr;
      end
    end else if (push) begin
      if (is_full) begin
        overflow_d = 1'b1;
      end else begin
        we    = 1'b1;
        waddr = sp_q[AddrW-1:0];
        sp_d  = sp_q + SpW'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else begin
        sp_d = sp_m1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= d;
    end
  end

  assign q         = is_empty ? '0 : mem_q[top_addr];
  assign empty     = is_empty;
  assign full      = is_full;
  assign count     = sp_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack with hand-computed expectations.
module tb_return_stack;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             push;
  logic             pop;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  int n_tests = 0;
  int n_fail  = 0;

  return_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .clr      (clr),
    .d        (d),
    .q        (q),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one set of controls across a single rising edge; returns 1 time unit after it.
  task automatic cycle(input logic p, input logic po, input logic c, input logic [WIDTH-1:0] dv);
    push = p;
    pop  = po;
    clr  = c;
    d    = dv;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    clr  = 1'b0;
    d    = '0;
  endtask

  initial begin
    logic [WIDTH-1:0] lifo_exp [3];
    lifo_exp[0] = 10'h3FF;
    lifo_exp[1] = 10'h0A1;
    lifo_exp[2] = 10'h005;

    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    d     = '0;
    #12;
    check("rst_q", 32'(q), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full", 32'(full), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_unf", 32'(underflow), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // LIFO order
    cycle(1'b1, 1'b0, 1'b0, 10'h005);
    cycle(1'b1, 1'b0, 1'b0, 10'h0A1);
    cycle(1'b1, 1'b0, 1'b0, 10'h3FF);
    check("lifo_count", 32'(count), 32'h3);
    check("lifo_top", 32'(q), 32'h3FF);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lifo_pop%0d", i), 32'(q), 32'(lifo_exp[i]));
      cycle(1'b0, 1'b1, 1'b0, '0);
    end
    check("lifo_empty", 32'(empty), 32'h1);
    check("lifo_q0", 32'(q), 32'h0);

    // Asynchronous reset mid-sequence with sp=3 and underflow set
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 10'h011);
    cycle(1'b1, 1'b0, 1'b0, 10'h022);
    cycle(1'b1, 1'b0, 1'b0, 10'h033);
    check("pre_rst_count", 32'(count), 32'h3);
    check("pre_rst_unf", 32'(underflow), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_empty", 32'(empty), 32'h1);
    check("arst_count", 32'(count), 32'h0);
    check("arst_q", 32'(q), 32'h0);
    check("arst_ovf", 32'(overflow), 32'h0);
    check("arst_unf", 32'(underflow), 32'h0);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Overflow
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 10'(32'h010 + i));
    cycle(1'b1, 1'b0, 1'b0, 10'h2AA);
    check("ovf_full", 32'(full), 32'h1);
    check("ovf_count", 32'(count), 32'h8);
    check("ovf_q", 32'(q), 32'h017);
    check("ovf_flag", 32'(overflow), 32'h1);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("ovf_pop_q", 32'(q), 32'h016);
    check("ovf_sticky", 32'(overflow), 32'h1);

    // Underflow and push+pop on empty
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("clr_count", 32'(count), 32'h0);
    check("clr_ovf", 32'(overflow), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("unf_count", 32'(count), 32'h0);
    check("unf_flag", 32'(underflow), 32'h1);
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("unf_clr", 32'(underflow), 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 10'h123);
    check("pp_empty_count", 32'(count), 32'h1);
    check("pp_empty_q", 32'(q), 32'h123);
    check("pp_empty_unf", 32'(underflow), 32'h1);

    // Replace-top
    cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b0, 1'b0, 10'h001);
    cycle(1'b1, 1'b0, 1'b0, 10'h002);
    check("rep_before_q", 32'(q), 32'h002);
    cycle(1'b1, 1'b1, 1'b0, 10'h0FE);
    check("rep_count", 32'(count), 32'h2);
    check("rep_q", 32'(q), 32'h0FE);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("rep_pop_q", 32'(q), 32'h001);
    cycle(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 10'(32'h100 + i));
    cycle(1'b1, 1'b1, 1'b0, 10'h055);
    check("rep_full_count", 32'(count), 32'h8);
    check("rep_full_ovf", 32'(overflow), 32'h0);
    check("rep_full_q", 32'(q), 32'h055);
    check("rep_full_unf", 32'(underflow), 32'h0);

    // clr beats push+pop
    cycle(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 10'(32'h200 + i));
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("clrp_pre_unf", 32'(underflow), 32'h1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 10'(32'h200 + i));
    check("clrp_pre_count", 32'(count), 32'h4);
    cycle(1'b1, 1'b1, 1'b1, 10'h3AB);
    check("clrp_count", 32'(count), 32'h0);
    check("clrp_empty", 32'(empty), 32'h1);
    check("clrp_q", 32'(q), 32'h0);
    check("clrp_ovf", 32'(overflow), 32'h0);
    check("clrp_unf", 32'(underflow), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
